lfsr_checker: RTL and testbench

- Receive-side companion to the team's Fibonacci LFSR generator. Consumes the serial bit stream the generator emits, which is the feedback bit shifted into bit 0 on each step.
- Self-synchronises a local N-bit LFSR to the stream, declares lock, then checks every later bit against the local prediction.
- Reports a per-bit error pulse, a saturating error count, lock status, and a once-per-period marker.
- Sits in the test and loopback path after the generator or the channel.

---
 rtl/lfsr_checker.sv | 201 ++++++++++++++++++++
 tb/tb_lfsr_checker.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker
// Receive-side companion to the Fibonacci LFSR generator. It locks a local
// N-bit LFSR onto the received serial stream, then checks every later bit
// against the local prediction.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   clear_cnt    synchronous clear of err_count
//   in_valid     qualifies in_bit; only qualified cycles advance state
//   in_bit       received serial bit (generator feedback bit)
//   locked       high while the checker is locked to the stream
//   bit_err      one-cycle pulse when a checked bit mismatches while locked
//   err_count    saturating count of mismatches seen while locked
//   period_done  one-cycle pulse after every 2^N-1 checked bits while locked
module lfsr_checker #(
    parameter int N            = 4,
    parameter int LOCK_MATCHES = 8,
    parameter int LOSS_ERRS    = 3,
    parameter int CW           = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_cnt,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          locked,
    output logic          bit_err,
    output logic [CW-1:0] err_count,
    output logic          period_done
);

    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int RW = $clog2(LOSS_ERRS + 1);

    // Terminal values: each counter acts on the bit that would make it reach
    // its target, so the comparison is against target-1.
    localparam logic [FW-1:0] FILL_LAST   = FW'(N - 1);
    localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_MATCHES - 1);
    localparam logic [RW-1:0] LOSS_LAST   = RW'(LOSS_ERRS - 1);
    localparam logic [N-1:0]  PERIOD_LAST = {{(N-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [FW-1:0] fillCnt_q, fillCnt_d;
    logic [MW-1:0] matchCnt_q, matchCnt_d;
    logic [RW-1:0] runCnt_q, runCnt_d;
    logic [N-1:0]  periodCnt_q, periodCnt_d;
    logic [CW-1:0] errCount_q, errCount_d;
    logic          locked_q, locked_d;
    logic          bitErr_q, bitErr_d;
    logic          periodDone_q, periodDone_d;

    logic          predBit;
    logic          errHit;
    logic [N-1:0]  srShiftIn;
    logic [N-1:0]  srShiftRef;

    // Feedback taps must match the generator; only the branch for the
    // configured width is elaborated.
    generate
        if (N == 2) begin : g_tap2
            assign predBit = sr_q[1] ^ sr_q[0];
        end else if (N == 3) begin : g_tap3
            assign predBit = sr_q[2] ^ sr_q[1];
        end else if (N == 4) begin : g_tap4
            assign predBit = sr_q[3] ^ sr_q[2];
        end else if (N == 5) begin : g_tap5
            assign predBit = sr_q[4] ^ sr_q[2];
        end else if (N == 6) begin : g_tap6
            assign predBit = sr_q[5] ^ sr_q[4];
        end else if (N == 7) begin : g_tap7
            assign predBit = sr_q[6] ^ sr_q[5];
        end else begin : g_tap8
            assign predBit = sr_q[7] ^ sr_q[5] ^ sr_q[4] ^ sr_q[3];
        end
    endgenerate

    // Next-state logic. While locked the register is driven by its own
    // prediction, so one flipped input bit produces exactly one error; on
    // loss of lock the received bit is shifted in again to restart self-sync.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        fillCnt_d    = fillCnt_q;
        matchCnt_d   = matchCnt_q;
        runCnt_d     = runCnt_q;
        periodCnt_d  = periodCnt_q;
        errCount_d   = errCount_q;
        bitErr_d     = 1'b0;
        periodDone_d = 1'b0;
        errHit       = 1'b0;
        srShiftIn    = {sr_q[N-2:0], in_bit};
        srShiftRef   = {sr_q[N-2:0], predBit};

        if (in_valid) begin
            unique case (state_q)
                FILL: begin
                    sr_d = srShiftIn;
                    if (fillCnt_q == FILL_LAST) begin
                        state_d    = ACQUIRE;
                        fillCnt_d  = '0;
                        matchCnt_d = '0;
                    end else begin
                        fillCnt_d = fillCnt_q + 1'b1;
                    end
                end

                ACQUIRE: begin
                    sr_d = srShiftIn;
                    // An all-zero register is the lockup state and would
                    // trivially predict a zero stream, so it never counts.
                    if ((in_bit == predBit) && (sr_q != '0)) begin
                        matchCnt_d = matchCnt_q + 1'b1;
                        if (matchCnt_q == LOCK_LAST) begin
                            state_d     = LOCKED;
                            periodCnt_d = '0;
                            runCnt_d    = '0;
                        end
                    end else begin
                        matchCnt_d = '0;
                    end
                end

                LOCKED: begin
                    periodDone_d = (periodCnt_q == PERIOD_LAST);
                    periodCnt_d  = (periodCnt_q == PERIOD_LAST) ? '0
                                                                : periodCnt_q + 1'b1;
                    if (in_bit != predBit) begin
                        errHit   = 1'b1;
                        bitErr_d = 1'b1;
                        runCnt_d = runCnt_q + 1'b1;
                        if (runCnt_q == LOSS_LAST) begin
                            state_d    = ACQUIRE;
                            matchCnt_d = '0;
                            sr_d       = srShiftIn;
                        end else begin
                            sr_d = srShiftRef;
                        end
                    end else begin
                        runCnt_d = '0;
                        sr_d     = srShiftRef;
                    end
                end

                default: begin
                    state_d = FILL;
                end
            endcase
        end

        // A clear coinciding with a counted error leaves that error counted.
        if (clear_cnt) begin
            errCount_d = errHit ? CW'(1) : '0;
        end else if (errHit && (errCount_q != '1)) begin
            errCount_d = errCount_q + 1'b1;
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            sr_q         <= '0;
            fillCnt_q    <= '0;
            matchCnt_q   <= '0;
            runCnt_q     <= '0;
            periodCnt_q  <= '0;
            errCount_q   <= '0;
            locked_q     <= 1'b0;
            bitErr_q     <= 1'b0;
            periodDone_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            fillCnt_q    <= fillCnt_d;
            matchCnt_q   <= matchCnt_d;
            runCnt_q     <= runCnt_d;
            periodCnt_q  <= periodCnt_d;
            errCount_q   <= errCount_d;
            locked_q     <= locked_d;
            bitErr_q     <= bitErr_d;
            periodDone_q <= periodDone_d;
        end
    end

    assign locked      = locked_q;
    assign bit_err     = bitErr_q;
    assign err_count   = errCount_q;
    assign period_done = periodDone_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
// Self-checking bench for lfsr_checker (N=4). Drives the generator's
// 15-bit period, directed corner cases and randomized traffic, and compares
// against a queue-based reference model of the checker's behaviour.
module tb_lfsr_checker;

    localparam int N            = 4;
    localparam int LOCK_MATCHES = 8;
    localparam int LOSS_ERRS    = 3;
    localparam int CW           = 16;
    localparam int PERIOD       = 15;
    localparam int NVEC         = 60;

    localparam int M_FILL    = 0;
    localparam int M_ACQUIRE = 1;
    localparam int M_LOCKED  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_cnt;
    logic          in_valid;
    logic          in_bit;
    logic          locked;
    logic          bit_err;
    logic [CW-1:0] err_count;
    logic          period_done;

    int checks = 0;
    int errors = 0;

    // Generator seeded 0001, one period.
    bit streamBits [PERIOD] = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    int pos;

    // Reference model: the local register is a queue of the last N bits,
    // oldest first; counters are plain integers.
    int mMode;
    int mFill;
    int mMatch;
    int mRun;
    int mChecked;
    bit hist[$];
    bit expLocked;
    bit expBitErr;
    bit expPeriodDone;
    int expErrCount;

    typedef struct {
        bit v;
        bit b;
        bit expLocked;
        bit expBitErr;
        bit expPd;
        int expCnt;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    lfsr_checker #(
        .N(N),
        .LOCK_MATCHES(LOCK_MATCHES),
        .LOSS_ERRS(LOSS_ERRS),
        .CW(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear_cnt(clear_cnt),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .locked(locked),
        .bit_err(bit_err),
        .err_count(err_count),
        .period_done(period_done)
    );

    task automatic modelReset();
        mMode    = M_FILL;
        mFill    = 0;
        mMatch   = 0;
        mRun     = 0;
        mChecked = 0;
        hist.delete();
        for (int i = 0; i < N; i++) hist.push_back(1'b0);
        expLocked     = 1'b0;
        expBitErr     = 1'b0;
        expPeriodDone = 1'b0;
        expErrCount   = 0;
    endtask

    task automatic shiftIn(input bit x);
        void'(hist.pop_front());
        hist.push_back(x);
    endtask

    task automatic modelStep(input bit v, input bit b, input bit clr);
        bit p;
        bit nonZero;
        bit errNow;
        errNow        = 1'b0;
        expPeriodDone = 1'b0;
        if (v) begin
            // Taps x^4+x^3+1: the two oldest bits of the window.
            p = hist[0] ^ hist[1];
            nonZero = 1'b0;
            foreach (hist[i]) nonZero |= hist[i];
            if (mMode == M_FILL) begin
                shiftIn(b);
                mFill++;
                if (mFill == N) begin
                    mMode  = M_ACQUIRE;
                    mMatch = 0;
                end
            end else if (mMode == M_ACQUIRE) begin
                shiftIn(b);
                if (b == p && nonZero) mMatch++;
                else mMatch = 0;
                if (mMatch == LOCK_MATCHES) begin
                    mMode    = M_LOCKED;
                    mChecked = 0;
                    mRun     = 0;
                end
            end else begin
                mChecked++;
                if (mChecked % PERIOD == 0) expPeriodDone = 1'b1;
                if (b != p) begin
                    errNow = 1'b1;
                    mRun++;
                    if (mRun == LOSS_ERRS) begin
                        mMode  = M_ACQUIRE;
                        mMatch = 0;
                        shiftIn(b);
                    end else begin
                        shiftIn(p);
                    end
                end else begin
                    mRun = 0;
                    shiftIn(p);
                end
            end
        end
        if (clr) expErrCount = errNow ? 1 : 0;
        else if (errNow && expErrCount < (1 << CW) - 1) expErrCount++;
        expBitErr = errNow;
        expLocked = (mMode == M_LOCKED);
    endtask

    task automatic applyStimulus(input bit v, input bit b, input bit clr);
        @(negedge clk);
        in_valid  = v;
        in_bit    = b;
        clear_cnt = clr;
        @(posedge clk);
        modelStep(v, b, clr);
        #1;
    endtask

    task automatic checkOutput(input string name);
        checks++;
        if (locked !== expLocked || bit_err !== expBitErr ||
            period_done !== expPeriodDone || err_count !== CW'(expErrCount)) begin
            errors++;
            $display("[TB] FAIL %s: got locked=%0b bit_err=%0b period_done=%0b err_count=%0d, expected locked=%0b bit_err=%0b period_done=%0b err_count=%0d",
                     name, locked, bit_err, period_done, err_count,
                     expLocked, expBitErr, expPeriodDone, expErrCount);
        end
    endtask

    task automatic checkVec(input string name, input int idx, input vec_t e);
        checks++;
        if (locked !== e.expLocked || bit_err !== e.expBitErr ||
            period_done !== e.expPd || err_count !== CW'(e.expCnt)) begin
            errors++;
            $display("[TB] FAIL %s[%0d]: got locked=%0b bit_err=%0b period_done=%0b err_count=%0d, expected locked=%0b bit_err=%0b period_done=%0b err_count=%0d",
                     name, idx, locked, bit_err, period_done, err_count,
                     e.expLocked, e.expBitErr, e.expPd, e.expCnt);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clear_cnt = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_state");
        @(negedge clk);
        reset = 1'b0;
        pos   = 0;
    endtask

    task automatic sendClean(input int count, input string name);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b1, streamBits[pos % PERIOD], 1'b0);
            pos++;
            checkOutput(name);
        end
    endtask

    task automatic sendFlip(input bit clr, input string name);
        applyStimulus(1'b1, ~streamBits[pos % PERIOD], clr);
        pos++;
        checkOutput(name);
    endtask

    initial begin
        int n;
        bit seenLock;
        int flipLeft;
        bit v;
        bit b;
        bit clr;

        reset     = 1'b1;
        clear_cnt = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        pos       = 0;
        modelReset();

        // Continuous clean stream: lock on bit 12, period pulses on bits
        // 27, 42 and 57, never an error.
        for (int k = 1; k <= NVEC; k++) begin
            vecs[k-1].v         = 1'b1;
            vecs[k-1].b         = streamBits[(k-1) % PERIOD];
            vecs[k-1].expLocked = (k >= 12);
            vecs[k-1].expBitErr = 1'b0;
            vecs[k-1].expPd     = (k == 27 || k == 42 || k == 57);
            vecs[k-1].expCnt    = 0;
        end

        doReset();
        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(vecs[k].v, vecs[k].b, 1'b0);
            checkVec("continuous", k + 1, vecs[k]);
        end

        // Same stream with idle cycles interleaved: bit-indexed timing holds.
        doReset();
        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            checkOutput("alternate_idle");
            applyStimulus(1'b1, vecs[k].b, 1'b0);
            checkVec("alternate_valid", k + 1, vecs[k]);
        end

        // One flipped bit after lock.
        doReset();
        sendClean(20, "single_pre");
        checkValue("single_locked_before", int'(locked), 1);
        sendFlip(1'b0, "single_flip");
        checkValue("single_bit_err", int'(bit_err), 1);
        checkValue("single_err_count", int'(err_count), 1);
        checkValue("single_still_locked", int'(locked), 1);
        sendClean(30, "single_post");
        checkValue("single_err_count_final", int'(err_count), 1);

        // Three consecutive flips drop lock; clean stream must relock.
        doReset();
        sendClean(20, "triple_pre");
        sendFlip(1'b0, "triple_flip1");
        sendFlip(1'b0, "triple_flip2");
        checkValue("triple_locked_after_2", int'(locked), 1);
        sendFlip(1'b0, "triple_flip3");
        checkValue("triple_lock_lost", int'(locked), 0);
        checkValue("triple_err_count", int'(err_count), 3);
        n = 0;
        while (locked !== 1'b1 && n < N + 8) begin
            sendClean(1, "triple_relock");
            n++;
        end
        checkValue("triple_relock_within_bound", int'(locked), 1);

        // All-zero stream never locks.
        doReset();
        seenLock = 1'b0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("zero_stream");
            if (locked === 1'b1) seenLock = 1'b1;
        end
        checkValue("zero_never_locked", int'(seenLock), 0);
        checkValue("zero_err_count", int'(err_count), 0);

        // clear_cnt interaction with a counted error.
        doReset();
        sendClean(20, "clear_pre");
        sendFlip(1'b0, "clear_flipA");
        sendClean(5, "clear_mid");
        sendFlip(1'b0, "clear_flipB");
        sendClean(5, "clear_mid2");
        checkValue("clear_count_two", int'(err_count), 2);
        sendFlip(1'b1, "clear_with_error");
        checkValue("clear_with_error_count", int'(err_count), 1);
        sendClean(3, "clear_post");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clear_alone");
        checkValue("clear_alone_count", int'(err_count), 0);
        checkValue("clear_alone_locked", int'(locked), 1);

        // Randomized traffic: idle gaps, isolated flips, flip bursts, clears.
        doReset();
        flipLeft = 0;
        for (int k = 0; k < 600; k++) begin
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            b   = streamBits[pos % PERIOD];
            if (v) begin
                if (flipLeft == 0 && $urandom_range(0, 59) == 0) flipLeft = 3;
                if (flipLeft > 0) begin
                    b = ~b;
                    flipLeft--;
                end else if ($urandom_range(0, 19) == 0) begin
                    b = ~b;
                end
                pos++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            applyStimulus(v, b, clr);
            checkOutput("random");
        end

        // Asynchronous reset asserted between edges while locked.
        doReset();
        sendClean(20, "async_pre");
        sendFlip(1'b0, "async_flip");
        checkValue("async_locked_before", int'(locked), 1);
        #2;
        reset = 1'b1;
        #1;
        checkValue("async_locked", int'(locked), 0);
        checkValue("async_bit_err", int'(bit_err), 0);
        checkValue("async_err_count", int'(err_count), 0);
        checkValue("async_period_done", int'(period_done), 0);
        modelReset();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pos   = 0;
        sendClean(12, "async_relock");
        checkValue("async_relock_locked", int'(locked), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
